// File: rtl/sobel_bin.sv
// Binary Sobel edge detector: 3x3 window from two line buffers, |Gx|+|Gy| against THRESH.
// Three-stage pipeline; valid/sop/eop and the border mask travel alongside the data.
module sobel_bin #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter logic [3:0]  THRESH = 4'd3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  input  logic din_vld,
  input  logic din_sop,
  input  logic din_eop,
  output logic dout,
  output logic dout_vld,
  output logic dout_sop,
  output logic dout_eop
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;

  logic r_lb0 [IMG_W];
  logic r_lb1 [IMG_W];
  logic w_lb0;
  logic w_lb1;

  // Window rows: r_p0 oldest line, r_p2 current line; bit j is column j (0 oldest).
  logic [2:0] r_p0, r_p1, r_p2;
  logic       r_s1_vld, r_s1_sop, r_s1_eop, r_s1_ok;

  logic [2:0] w_posx, w_negx, w_posy, w_negy;
  logic [2:0] w_absx, w_absy;
  logic [3:0] w_mag;
  logic [3:0] r_mag;
  logic       r_s2_vld, r_s2_sop, r_s2_eop, r_s2_ok;

  // A sop pixel is (0,0) no matter where the counters were left.
  assign w_col = din_sop ? '0 : r_col;
  assign w_row = din_sop ? '0 : r_row;
  assign w_lb0 = r_lb0[w_col];
  assign w_lb1 = r_lb1[w_col];

  always_ff @(posedge clk) begin
    if (din_vld) begin
      r_lb1[w_col] <= din;
      r_lb0[w_col] <= w_lb1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_p0     <= '0;
      r_p1     <= '0;
      r_p2     <= '0;
      r_s1_vld <= 1'b0;
      r_s1_sop <= 1'b0;
      r_s1_eop <= 1'b0;
      r_s1_ok  <= 1'b0;
    end else begin
      r_s1_vld <= din_vld;
      r_s1_sop <= din_vld & din_sop;
      r_s1_eop <= din_vld & din_eop;
      r_s1_ok  <= din_vld && (w_row >= RW'(2)) && (w_col >= CW'(2));
      if (din_vld) begin
        r_p0 <= {w_lb0, r_p0[2:1]};
        r_p1 <= {w_lb1, r_p1[2:1]};
        r_p2 <= {din,   r_p2[2:1]};
        if (din_eop) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? w_row : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  always_comb begin
    w_posx = {2'b00, r_p0[2]} + {1'b0, r_p1[2], 1'b0} + {2'b00, r_p2[2]};
    w_negx = {2'b00, r_p0[0]} + {1'b0, r_p1[0], 1'b0} + {2'b00, r_p2[0]};
    w_posy = {2'b00, r_p2[0]} + {1'b0, r_p2[1], 1'b0} + {2'b00, r_p2[2]};
    w_negy = {2'b00, r_p0[0]} + {1'b0, r_p0[1], 1'b0} + {2'b00, r_p0[2]};
    w_absx = (w_posx >= w_negx) ? (w_posx - w_negx) : (w_negx - w_posx);
    w_absy = (w_posy >= w_negy) ? (w_posy - w_negy) : (w_negy - w_posy);
    w_mag  = {1'b0, w_absx} + {1'b0, w_absy};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag    <= '0;
      r_s2_vld <= 1'b0;
      r_s2_sop <= 1'b0;
      r_s2_eop <= 1'b0;
      r_s2_ok  <= 1'b0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      r_mag    <= w_mag;
      r_s2_vld <= r_s1_vld;
      r_s2_sop <= r_s1_sop;
      r_s2_eop <= r_s1_eop;
      r_s2_ok  <= r_s1_ok;
      dout     <= r_s2_vld & r_s2_ok & (r_mag >= THRESH);
      dout_vld <= r_s2_vld;
      dout_sop <= r_s2_sop;
      dout_eop <= r_s2_eop;
    end
  end

endmodule

// File: tb/tb_sobel_bin.sv
// Directed bench for sobel_bin on an 8x6 frame; a second instance runs with THRESH=2.
module tb_sobel_bin;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic din = 1'b0, din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic dout, dout_vld, dout_sop, dout_eop;
  logic dout2, dout2_vld, dout2_sop, dout2_eop;

  always #5 clk = ~clk;

  sobel_bin #(.IMG_W(8), .IMG_H(6), .THRESH(4'd3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
    .dout_eop(dout_eop)
  );

  sobel_bin #(.IMG_W(8), .IMG_H(6), .THRESH(4'd2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
    .din_eop(din_eop), .dout(dout2), .dout_vld(dout2_vld), .dout_sop(dout2_sop),
    .dout_eop(dout2_eop)
  );

  typedef struct {
    int          pat;   // 0 all ones, 1 vertical edge at col 4, 2 single one at (3,3)
    bit          gaps;
    logic [47:0] m3;    // expected map, bit r*8+c, THRESH=3
    logic [47:0] m2;    // expected map, THRESH=2
  } vec_t;

  localparam logic [47:0] MAP_VERT = 48'h3030_3030_0000;
  localparam logic [47:0] MAP_RING = 48'h3828_3800_0000;

  int checks = 0;
  int errors = 0;
  vec_t tbl [4];
  logic [3:0] q [$];        // {dout, dout2, dout_sop, dout_eop} per dout_vld
  logic [2:0] h1 = '0, h2 = '0, h3 = '0;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic pix(input int pat, input int r, input int c);
    case (pat)
      0:       return 1'b1;
      1:       return c >= 4;
      default: return (r == 3) && (c == 3);
    endcase
  endfunction

  task automatic step_mon();
    if (!rst_n) begin
      chk("outputs_in_reset",
          {dout, dout_vld, dout_sop, dout_eop, dout2, dout2_vld, dout2_sop, dout2_eop}, 8'h00);
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
      chk("latency3_vld_sop_eop", {dout_vld, dout_sop, dout_eop}, h3);
      chk("latency3_vld_sop_eop_t2", {dout2_vld, dout2_sop, dout2_eop}, h3);
      if (!dout_vld) chk("dout_zero_when_idle", dout, 1'b0);
      if (dout_vld) q.push_back({dout, dout2, dout_sop, dout_eop});
      h3 = h2; h2 = h1;
      h1 = {din_vld, din_vld & din_sop, din_vld & din_eop};
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic s, input logic e);
    din_vld = v; din = d; din_sop = s; din_eop = e;
    @(negedge clk);
    step_mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int pat, input bit gaps);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (gaps) while ($urandom_range(0, 9) < 3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, pix(pat, r, c), (r == 0) && (c == 0), (r == 5) && (c == 7));
      end
    end
  endtask

  task automatic drain();
    repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_frame(input int base, input logic [47:0] m3, input logic [47:0] m2,
                             input string tag);
    logic [3:0] e;
    if (q.size() < base + 48) begin
      chk({tag, "_short_output"}, 8'(q.size()), 8'(base + 48));
      return;
    end
    for (int k = 0; k < 48; k++) begin
      e = q[base + k];
      chk($sformatf("%s_dout_px%0d", tag, k), e[3], m3[k]);
      chk($sformatf("%s_dout_t2_px%0d", tag, k), e[2], m2[k]);
      chk($sformatf("%s_sop_px%0d", tag, k), e[1], k == 0);
      chk($sformatf("%s_eop_px%0d", tag, k), e[0], k == 47);
    end
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 48'h0, 48'h0};
    tbl[1] = '{1, 1'b0, MAP_VERT, MAP_VERT};
    tbl[2] = '{2, 1'b0, 48'h0, MAP_RING};
    tbl[3] = '{1, 1'b1, MAP_VERT, MAP_VERT};

    #1 rst_n = 1'b0;
    #1 chk("reset_state",
           {dout, dout_vld, dout_sop, dout_eop, dout2, dout2_vld, dout2_sop, dout2_eop}, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      q.delete();
      send_frame(tbl[i].pat, tbl[i].gaps);
      drain();
      chk($sformatf("vec%0d_count", i), 8'(q.size()), 8'd48);
      check_frame(0, tbl[i].m3, tbl[i].m2, $sformatf("vec%0d", i));
    end

    // Back-to-back: vertical edge then all ones, no idle between frames.
    q.delete();
    send_frame(1, 1'b0);
    send_frame(0, 1'b0);
    drain();
    chk("b2b_count", 8'(q.size()), 8'd96);
    check_frame(0, MAP_VERT, MAP_VERT, "b2b_f1");
    check_frame(48, 48'h0, 48'h0, "b2b_f2");

    // Asynchronous reset in the middle of a frame.
    q.delete();
    for (int k = 0; k < 20; k++) drive(1'b1, pix(1, k / 8, k % 8), k == 0, 1'b0);
    chk("pre_reset_vld", dout_vld, 1'b1);
    #2 rst_n = 1'b0;
    q.delete();
    #1 chk("async_reset_outputs",
           {dout, dout_vld, dout_sop, dout_eop, dout2, dout2_vld, dout2_sop, dout2_eop}, 8'h00);
    for (int k = 20; k < 23; k++) drive(1'b1, pix(1, k / 8, k % 8), 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (6) drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_frame1_after_reset", 8'(q.size()), 8'd0);
    q.delete();
    send_frame(1, 1'b0);
    drain();
    chk("post_reset_count", 8'(q.size()), 8'd48);
    check_frame(0, MAP_VERT, MAP_VERT, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
